ahb_uart_bridge_master: RTL

//  Byte-stream-to-AHB-Lite initiator: decodes command packets from the UART RX byte stream and

---
 rtl/ahb_uart_bridge_master_pkg.sv | 44 ++++
 rtl/bridge_byte_shifter.sv | 33 +++
 rtl/ahb_uart_bridge_master.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ahb_uart_bridge_master_pkg.sv
// Shared types and constants for the UART-to-AHB bridge master.
// State encoding, command/status bytes, AHB encodings, TX byte select.
package ahb_uart_bridge_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_AHB_ADDR,
    S_AHB_DATA,
    S_SEND
  } state_t;

  localparam logic [7:0] DEF_CMD_WR = 8'hA5;
  localparam logic [7:0] DEF_CMD_RD = 8'h5A;
  localparam logic [7:0] DEF_RSP_OK = 8'hAC;
  localparam logic [7:0] DEF_RSP_ERR = 8'hEE;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA = 4'b0011;

  // Response byte idx: 0 = status, 1..4 = read data MSB first.
  function automatic logic [7:0] rsp_byte(
    input logic [7:0]  st,
    input logic [31:0] d,
    input logic [2:0]  idx
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (idx)
      3'd0: b = st;
      3'd1: b = d[31:24];
      3'd2: b = d[23:16];
      3'd3: b = d[15:8];
      3'd4: b = d[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bridge_byte_shifter.sv
// Four-byte MSB-first deserialiser with a 2-bit byte counter.
// Ports: i_clr (sync clear), i_shift/i_byte in; o_word_nxt, o_last out.
module bridge_byte_shifter (
  input  logic        clk,
  input  logic        RSTn,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_nxt,
  output logic        o_last
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;

  // Word including the byte being shifted in this cycle.
  assign o_word_nxt = {r_word[23:0], i_byte};
  assign o_last = i_shift && (r_cnt == 2'd3);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_word <= o_word_nxt;
      r_cnt  <= r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/ahb_uart_bridge_master.sv
// UART byte stream to AHB-Lite single-word initiator (debug/loader).
// Ports: rx_* byte in, tx_* byte out, AHB-Lite master, busy.
module ahb_uart_bridge_master
  import ahb_uart_bridge_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter logic [7:0]  CMD_WR      = DEF_CMD_WR,
  parameter logic [7:0]  CMD_RD      = DEF_CMD_RD,
  parameter logic [7:0]  RSP_OK      = DEF_RSP_OK,
  parameter logic [7:0]  RSP_ERR     = DEF_RSP_ERR
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy
);

  localparam int GW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYC - 1);

  state_t r_state;
  state_t w_next;

  logic          r_rdy_en;
  logic          r_write;
  logic [31:2]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [7:0]    r_status;
  logic [2:0]    r_tx_idx;
  logic [2:0]    r_tx_last;
  logic [GW-1:0] r_gap;

  logic        w_get;
  logic        w_acc;
  logic        w_is_cmd;
  logic        w_shift;
  logic        w_last;
  logic        w_timeout;
  logic [31:0] w_word_nxt;

  assign w_get = (r_state == S_GET_ADDR) ||
                 (r_state == S_GET_DATA);
  // Held low while in reset, enabled the first edge after.
  assign rx_ready = r_rdy_en &&
                    ((r_state == S_IDLE) || w_get);
  assign w_acc = rx_valid && rx_ready;
  assign w_is_cmd = (rx_data == CMD_WR) ||
                    (rx_data == CMD_RD);
  assign w_shift = w_acc && w_get;
  assign w_timeout = w_get && !w_acc &&
                     (r_gap == GAP_MAX);

  bridge_byte_shifter u_shift (
    .clk        (clk),
    .RSTn       (RSTn),
    .i_clr      (r_state == S_IDLE),
    .i_shift    (w_shift),
    .i_byte     (rx_data),
    .o_word_nxt (w_word_nxt),
    .o_last     (w_last)
  );

  assign HADDR     = {r_addr, 2'b00};
  assign HWRITE    = (r_state == S_AHB_ADDR) && r_write;
  assign HWDATA    = r_wdata;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    HTRANS   = HTRANS_IDLE;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc && w_is_cmd) w_next = S_GET_ADDR;
      end
      S_GET_ADDR: begin
        if (w_last)
          w_next = r_write ? S_GET_DATA : S_AHB_ADDR;
        else if (w_timeout)
          w_next = S_SEND;
      end
      S_GET_DATA: begin
        if (w_last)         w_next = S_AHB_ADDR;
        else if (w_timeout) w_next = S_SEND;
      end
      S_AHB_ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        if (HREADY) w_next = S_AHB_DATA;
      end
      S_AHB_DATA: begin
        if (HREADY) w_next = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = rsp_byte(r_status, r_rdata, r_tx_idx);
        if (tx_ready && (r_tx_idx == r_tx_last))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_rdy_en  <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_status  <= '0;
      r_tx_idx  <= '0;
      r_tx_last <= '0;
      r_gap     <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      // Gap only runs mid-packet; any accepted byte restarts it.
      if (w_get && !w_acc) r_gap <= r_gap + 1'b1;
      else                 r_gap <= '0;
      if ((r_state == S_IDLE) && w_acc && w_is_cmd)
        r_write <= (rx_data == CMD_WR);
      if ((r_state == S_GET_ADDR) && w_last)
        r_addr <= w_word_nxt[31:2];
      if ((r_state == S_GET_DATA) && w_last)
        r_wdata <= w_word_nxt;
      if (w_timeout) begin
        r_status  <= RSP_ERR;
        r_tx_last <= 3'd0;
        r_tx_idx  <= 3'd0;
      end
      if ((r_state == S_AHB_DATA) && HREADY) begin
        r_tx_idx <= 3'd0;
        if (HRESP) begin
          r_status  <= RSP_ERR;
          r_tx_last <= 3'd0;
        end else begin
          r_status  <= RSP_OK;
          r_tx_last <= r_write ? 3'd0 : 3'd4;
          if (!r_write) r_rdata <= HRDATA;
        end
      end
      if ((r_state == S_SEND) && tx_ready)
        r_tx_idx <= r_tx_idx + 3'd1;
    end
  end

endmodule
